// File: rtl/simplez_uart_tx_if.sv
// Simplez CPU memory-bus bundle as seen by a memory-mapped responder.
// The CPU (master) drives address/strobes/write data; the responder returns registered read data and hit.
interface simplez_uart_tx_if;
  logic [8:0]  address;
  logic        rd;
  logic        wr;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        hit;

  modport master (output address, rd, wr, data_in, input data_out, hit);
  modport slave  (input address, rd, wr, data_in, output data_out, hit);
endinterface

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the Simplez bus, updated on the falling clock edge.
// A holding register feeds a shift register so characters can be sent back-to-back.
module simplez_uart_tx #(
  parameter int         CLK_DIV     = 104,
  parameter logic [8:0] STATUS_ADDR = 9'd508,
  parameter logic [8:0] DATA_ADDR   = 9'd509
) (
  input  logic              clk,
  input  logic              rstn,
  simplez_uart_tx_if.slave  bus,
  output logic              tx,
  output logic              busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             tx_nx;
  logic             hold_full, hold_full_nx;
  logic [7:0]       hold_reg, hold_reg_nx;
  logic [7:0]       last_byte, last_byte_nx;
  logic             overrun, overrun_nx;
  logic [11:0]      data_out_q, data_out_nx;
  logic             hit_q, hit_nx;

  logic wr_data, rd_status, rd_data, accept, drop, div_end, load;
  logic unused_bits;

  assign unused_bits = ^bus.data_in[11:8];

  assign wr_data   = bus.wr && (bus.address == DATA_ADDR);
  assign rd_status = bus.rd && (bus.address == STATUS_ADDR);
  assign rd_data   = bus.rd && (bus.address == DATA_ADDR);
  assign accept    = wr_data && !hold_full;
  assign drop      = wr_data && hold_full;
  assign div_end   = (div == DIV_LAST);

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      div        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      hold_full  <= 1'b0;
      hold_reg   <= '0;
      last_byte  <= '0;
      overrun    <= 1'b0;
      data_out_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      bit_idx    <= bit_idx_nx;
      shift      <= shift_nx;
      tx         <= tx_nx;
      hold_full  <= hold_full_nx;
      hold_reg   <= hold_reg_nx;
      last_byte  <= last_byte_nx;
      overrun    <= overrun_nx;
      data_out_q <= data_out_nx;
      hit_q      <= hit_nx;
    end
  end

  // Shifter sequencing; 'load' moves the holding register into the shifter and starts a frame.
  always_comb begin
    state_nx   = state;
    div_nx     = div;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    tx_nx      = tx;
    load       = 1'b0;

    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (div_end) begin
          state_nx   = DATA;
          div_nx     = '0;
          bit_idx_nx = '0;
          tx_nx      = shift[0];
        end else begin
          div_nx = div + 1'b1;
        end
      end
      DATA: begin
        if (div_end) begin
          div_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
            shift_nx   = {1'b0, shift[7:1]};
            tx_nx      = shift[1];
          end
        end else begin
          div_nx = div + 1'b1;
        end
      end
      STOP: begin
        if (div_end) begin
          div_nx = '0;
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          div_nx = div + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase

    if (load) begin
      state_nx = START;
      shift_nx = hold_reg;
      div_nx   = '0;
      tx_nx    = 1'b0;
    end
  end

  // Bus side: a load only happens when full and a write is only accepted when empty, so they never collide.
  always_comb begin
    hold_full_nx = hold_full;
    hold_reg_nx  = hold_reg;
    last_byte_nx = last_byte;
    overrun_nx   = overrun;
    data_out_nx  = '0;
    hit_nx       = 1'b0;

    if (load) hold_full_nx = 1'b0;

    if (accept) begin
      hold_full_nx = 1'b1;
      hold_reg_nx  = bus.data_in[7:0];
      last_byte_nx = bus.data_in[7:0];
    end

    if (drop)
      overrun_nx = 1'b1;
    else if (rd_status)
      overrun_nx = 1'b0;

    if (rd_status) begin
      data_out_nx = {10'b0, overrun, !hold_full};
      hit_nx      = 1'b1;
    end else if (rd_data) begin
      data_out_nx = {4'b0, last_byte};
      hit_nx      = 1'b1;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.hit      = hit_q;
  assign busy         = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Directed self-checking bench for simplez_uart_tx with CLK_DIV=4.
// Inputs change on the rising edge; the DUT acts on the falling edge.
module tb_simplez_uart_tx;

  logic clk;
  logic rstn;
  logic tx;
  logic busy;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic tx_log[$];
  bit   logging = 0;

  simplez_uart_tx_if bus ();

  simplez_uart_tx #(.CLK_DIV(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records the line level just after every active edge while logging is on.
  always @(negedge clk) begin
    #1;
    if (logging) tx_log.push_back(tx);
  end

  task automatic check_output(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic w, input logic [8:0] a, input logic [11:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic check_frame(input int base, input logic [7:0] b, input string tag);
    logic e;
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < 4; c++)
        check_output($sformatf("%s_bit%0d_c%0d", tag, i, c), {11'b0, tx_log[base + i*4 + c]}, {11'b0, e});
    end
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (tx_log.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    check_output(tag, {11'b0, tx_log.size() >= n}, 12'h001);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      @(posedge clk);
      k++;
    end
    check_output(tag, {11'b0, busy}, 12'h000);
  endtask

  initial begin
    rstn        = 1'b0;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    check_output("rst_tx", {11'b0, tx}, 12'h001);
    check_output("rst_busy", {11'b0, busy}, 12'h000);
    check_output("rst_hit", {11'b0, bus.hit}, 12'h000);
    check_output("rst_dout", bus.data_out, 12'h000);
    rstn = 1'b1;
    @(posedge clk);

    // Single byte 0xA5
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h0A5);
    check_output("a5_tx_pre", {11'b0, tx}, 12'h001);
    check_output("a5_busy_pre", {11'b0, busy}, 12'h001);
    tx_log.delete();
    logging = 1;
    repeat (40) @(posedge clk);
    check_output("a5_busy_40", {11'b0, busy}, 12'h001);
    @(posedge clk);
    check_output("a5_busy_41", {11'b0, busy}, 12'h000);
    check_output("a5_tx_idle", {11'b0, tx}, 12'h001);
    logging = 0;
    check_frame(0, 8'hA5, "a5");
    apply_stimulus(1'b1, 1'b0, 9'd509, 12'h000);
    check_output("a5_rd_data", bus.data_out, 12'h0A5);
    check_output("a5_rd_hit", {11'b0, bus.hit}, 12'h001);
    apply_stimulus(1'b0, 1'b0, 9'd0, 12'h000);
    check_output("a5_hit_drop", {11'b0, bus.hit}, 12'h000);
    check_output("a5_dout_drop", bus.data_out, 12'h000);

    // Asynchronous reset mid-frame
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h03C);
    repeat (6) @(posedge clk);
    check_output("mid_tx_low", {11'b0, tx}, 12'h000);
    #2;
    rstn = 1'b0;
    #1;
    check_output("mid_rst_tx", {11'b0, tx}, 12'h001);
    check_output("mid_rst_busy", {11'b0, busy}, 12'h000);
    @(posedge clk);
    rstn = 1'b1;
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("mid_rst_status", bus.data_out, 12'h001);

    // Back-to-back frames 0x41, 0x42
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h041);
    tx_log.delete();
    logging = 1;
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("b2b_status_full", bus.data_out, 12'h000);
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("b2b_status_ready", bus.data_out, 12'h001);
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h042);
    wait_log(80, "b2b_log_timeout");
    logging = 0;
    check_frame(0, 8'h41, "b2b41");
    check_frame(40, 8'h42, "b2b42");
    wait_idle("b2b_idle_timeout");

    // Overrun: 0x33 dropped while 0x22 waits
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h011);
    tx_log.delete();
    logging = 1;
    apply_stimulus(1'b0, 1'b0, 9'd0, 12'h000);
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h022);
    apply_stimulus(1'b0, 1'b1, 9'd509, 12'h033);
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("ovr_status_set", bus.data_out, 12'h002);
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("ovr_status_clr", bus.data_out, 12'h000);
    wait_log(80, "ovr_log_timeout");
    logging = 0;
    check_frame(0, 8'h11, "ovr11");
    check_frame(40, 8'h22, "ovr22");
    wait_idle("ovr_idle_timeout");
    apply_stimulus(1'b1, 1'b0, 9'd509, 12'h000);
    check_output("ovr_last_byte", bus.data_out, 12'h022);

    // Address decode
    apply_stimulus(1'b0, 1'b1, 9'd507, 12'h0FF);
    check_output("dec507_wr_busy", {11'b0, busy}, 12'h000);
    apply_stimulus(1'b1, 1'b0, 9'd507, 12'h000);
    check_output("dec507_hit", {11'b0, bus.hit}, 12'h000);
    check_output("dec507_dout", bus.data_out, 12'h000);
    apply_stimulus(1'b0, 1'b1, 9'd510, 12'h0FF);
    check_output("dec510_wr_busy", {11'b0, busy}, 12'h000);
    apply_stimulus(1'b1, 1'b0, 9'd510, 12'h000);
    check_output("dec510_hit", {11'b0, bus.hit}, 12'h000);
    check_output("dec510_dout", bus.data_out, 12'h000);
    repeat (3) @(posedge clk);
    check_output("dec_tx_idle", {11'b0, tx}, 12'h001);
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("dec508_dout", bus.data_out, 12'h001);
    check_output("dec508_hit", {11'b0, bus.hit}, 12'h001);
    apply_stimulus(1'b0, 1'b0, 9'd0, 12'h000);
    check_output("dec508_hit_once", {11'b0, bus.hit}, 12'h000);
    apply_stimulus(1'b1, 1'b0, 9'd509, 12'h000);
    check_output("dec509_dout", bus.data_out, 12'h022);
    check_output("dec509_hit", {11'b0, bus.hit}, 12'h001);
    apply_stimulus(1'b0, 1'b0, 9'd0, 12'h000);
    check_output("dec509_hit_once", {11'b0, bus.hit}, 12'h000);
    check_output("dec509_dout_clr", bus.data_out, 12'h000);

    // Read and write strobes on the same edge
    apply_stimulus(1'b1, 1'b1, 9'd508, 12'h077);
    check_output("sim508_status", bus.data_out, 12'h001);
    check_output("sim508_busy", {11'b0, busy}, 12'h000);
    apply_stimulus(1'b1, 1'b1, 9'd509, 12'h05C);
    check_output("sim509_old_byte", bus.data_out, 12'h022);
    check_output("sim509_busy", {11'b0, busy}, 12'h001);
    apply_stimulus(1'b1, 1'b0, 9'd508, 12'h000);
    check_output("sim_status_held", bus.data_out, 12'h000);
    wait_idle("sim_idle_timeout");
    apply_stimulus(1'b1, 1'b0, 9'd509, 12'h000);
    check_output("sim_new_byte", bus.data_out, 12'h05C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
